// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Default 640x480@60 Hz raster timing and the pixel colour type
//                shared by the VGA scan controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Horizontal timing, in pixel clocks
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    // Vertical timing, in lines
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Sync regions sit after the front porch; end values are inclusive
    localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
    localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_scan_ctrl_sync_delay.sv
`default_nettype none
// ============================================================================
//  Module      : sync_delay
//  Description : WIDTH x DEPTH shift register with synchronous reset value.
//                Also exposes the entry feeding the last stage so a sibling
//                register can be loaded in step with the tail.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_pre,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    // Shift one stage per clock; reset loads every stage with RST_VAL
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign o_q = stage_q[DEPTH-1];

    // With a single stage the tail is fed straight from the input
    generate
        if (DEPTH == 1) begin : g_pre_input
            assign o_pre = i_d;
        end else begin : g_pre_stage
            assign o_pre = stage_q[DEPTH-2];
        end
    endgenerate

endmodule : sync_delay
`default_nettype wire

// File: rtl/vga_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scan_ctrl
//  Description : Raster counters, frame ROM coordinate bus, colour register
//                with blanking, and HSYNC/VSYNC delayed to match the colour.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int PIPE_DELAY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [9:0]  o_x,
    output logic [8:0]  o_y,
    input  logic [23:0] i_rgb,
    output logic [7:0]  o_vga_r,
    output logic [7:0]  o_vga_g,
    output logic [7:0]  o_vga_b,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_blank_n,
    output logic        o_sync_n,
    output logic        o_frame_start
);

    // Full-width counter thresholds for this instance's timing
    localparam logic [9:0] C_H_ACTIVE = 10'(H_ACTIVE);
    localparam logic [9:0] C_V_ACTIVE = 10'(V_ACTIVE);
    localparam logic [9:0] C_H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] C_V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] C_HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] C_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] C_VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] C_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       active;
    logic       hs_raw;
    logic       vs_raw;
    logic [2:0] pipe_pre;
    logic [2:0] pipe_tail;
    rgb_t       rgb_q, rgb_d;

    // Next raster position: h wraps every line, v advances only on h wrap
    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == C_H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == C_V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end
    end

    // Raster position registers; reset aborts the scan and restarts at (0,0)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Region decode on the full-width counters
    always_comb begin
        active = (h_cnt_q < C_H_ACTIVE) && (v_cnt_q < C_V_ACTIVE);
        hs_raw = !((h_cnt_q >= C_HS_START) && (h_cnt_q <= C_HS_END));
        vs_raw = !((v_cnt_q >= C_VS_START) && (v_cnt_q <= C_VS_END));
    end

    // Coordinates are parked at 0 outside the visible area to keep the ROM
    // address in range; v_cnt only fits 9 bits while active
    assign o_x = active ? h_cnt_q : 10'd0;
    assign o_y = active ? v_cnt_q[8:0] : 9'd0;

    assign o_frame_start = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0) && !i_rst;
    assign o_sync_n      = 1'b0;

    sync_delay #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (3'b011)
    ) u_pipe (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   ({active, hs_raw, vs_raw}),
        .o_pre (pipe_pre),
        .o_q   (pipe_tail)
    );

    // Colour is accepted only when the matching delayed active bit is set
    always_comb begin
        rgb_d = pipe_pre[2] ? rgb_t'(i_rgb) : '0;
    end

    // Colour register loads alongside the tail of the sync pipe
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign o_vga_r   = rgb_q.r;
    assign o_vga_g   = rgb_q.g;
    assign o_vga_b   = rgb_q.b;
    assign o_blank_n = pipe_tail[2];
    assign o_hs      = pipe_tail[1];
    assign o_vs      = pipe_tail[0];

endmodule : vga_scan_ctrl
`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_scan_ctrl
//  Description : Directed bench for vga_scan_ctrl: default timing at
//                PIPE_DELAY 1 and 3 with echo ROMs, plus a short-frame
//                instance driven with white for frame-level behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Instance 1: default timing, combinational echo ROM
    logic [9:0]  x1;  logic [8:0] y1;  logic [23:0] rgb1;
    logic [7:0]  r1, g1, b1;
    logic        hs1, vs1, bl1, sn1, fs1;
    assign rgb1 = {x1[7:0], y1[7:0], 8'hA5};

    vga_scan_ctrl #(.PIPE_DELAY(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .o_x(x1), .o_y(y1), .i_rgb(rgb1),
        .o_vga_r(r1), .o_vga_g(g1), .o_vga_b(b1), .o_hs(hs1), .o_vs(vs1),
        .o_blank_n(bl1), .o_sync_n(sn1), .o_frame_start(fs1));

    // Instance 3: default timing, ROM with two cycles of latency
    logic [9:0]  x3;  logic [8:0] y3;  logic [23:0] rgb3, echo_d1, echo_d2;
    logic [7:0]  r3, g3, b3;
    logic        hs3, vs3, bl3, sn3, fs3;
    always @(posedge clk) begin
        echo_d1 <= {x3[7:0], y3[7:0], 8'hA5};
        echo_d2 <= echo_d1;
    end
    assign rgb3 = echo_d2;

    vga_scan_ctrl #(.PIPE_DELAY(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .o_x(x3), .o_y(y3), .i_rgb(rgb3),
        .o_vga_r(r3), .o_vga_g(g3), .o_vga_b(b3), .o_hs(hs3), .o_vs(vs3),
        .o_blank_n(bl3), .o_sync_n(sn3), .o_frame_start(fs3));

    // Instance F: short frame (6 active + 2 + 2 + 3 = 13 lines), white input
    logic [9:0]  xf;  logic [8:0] yf;
    logic [7:0]  rf, gf, bf;
    logic        hsf, vsf, blf, snf, fsf;

    vga_scan_ctrl #(.V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(1)) u_dutf (
        .i_clk(clk), .i_rst(rst), .o_x(xf), .o_y(yf), .i_rgb(24'hFFFFFF),
        .o_vga_r(rf), .o_vga_g(gf), .o_vga_b(bf), .o_hs(hsf), .o_vs(vsf),
        .o_blank_n(blf), .o_sync_n(snf), .o_frame_start(fsf));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int hs_low, hs_first, bl_cnt, fs1_cnt;
        int vs_low, vs_first, fsf_cnt, fsf_at, ymax, coord_err, white_err, blf_cnt;
        int exp_x, exp_y, hh, vv;
        int hs3_first;

        // ---------------- reset held 5 cycles ----------------
        rst = 1'b1;
        repeat (5) tick();
        chk("rst_hs",    32'(hs1), 32'd1);
        chk("rst_vs",    32'(vs1), 32'd1);
        chk("rst_blank", 32'(bl1), 32'd0);
        chk("rst_rgb",   32'({r1, g1, b1}), 32'd0);
        chk("rst_fs",    32'(fs1), 32'd0);
        chk("rst_blank3", 32'(bl3), 32'd0);
        chk("sync_n",    32'(sn1), 32'd0);

        // ---------------- release: cycle 0 issues (0,0) ----------------
        rst = 1'b0;
        #1;
        cyc = 0;
        chk("rel_fs", 32'(fs1), 32'd1);
        chk("rel_x",  32'(x1),  32'd0);
        chk("rel_y",  32'(y1),  32'd0);
        chk("rel_fsf", 32'(fsf), 32'd1);

        hs_low = 0; hs_first = -1; bl_cnt = 0; fs1_cnt = 0; hs3_first = -1;
        vs_low = 0; vs_first = -1; fsf_cnt = 0; fsf_at = -1; ymax = 0;
        coord_err = 0; white_err = 0; blf_cnt = 0;

        for (int n = 1; n <= 10401; n++) begin
            tick();
            // first line on instance 1: pins show cycle n-1
            if (n <= 800) begin
                if (!hs1) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = n;
                end
                if (bl1) bl_cnt++;
                if (!hs3 && hs3_first < 0) hs3_first = n;
            end
            if (n == 1) chk("first_pix_blank1", 32'(bl1), 32'd1);
            if (n == 2) chk("first_pix_blank3_early", 32'(bl3), 32'd0);
            if (n == 3) chk("first_pix_blank3", 32'(bl3), 32'd1);
            if (n == 700) begin
                chk("hblank_x", 32'(x1), 32'd0);
                chk("hblank_y", 32'(y1), 32'd0);
            end
            if (n == 5605) begin
                chk("coord_x_5_7", 32'(x1), 32'd5);
                chk("coord_y_5_7", 32'(y1), 32'd7);
                chk("echo1_prev", 32'(r1), 32'h04);
            end
            if (n == 5606) chk("echo1_5_7", 32'({r1, g1, b1}), 32'h0507A5);
            if (n == 5607) chk("echo3_prev", 32'(r3), 32'h04);
            if (n == 5608) begin
                chk("echo3_5_7", 32'({r3, g3, b3}), 32'h0507A5);
                chk("echo3_blank", 32'(bl3), 32'd1);
            end
            if (fs1) fs1_cnt++;

            // short-frame instance: full first frame
            if (n <= 10400) begin
                if (!vsf) begin
                    vs_low++;
                    if (vs_first < 0) vs_first = n;
                end
                if (blf) blf_cnt++;
                if (fsf) begin
                    fsf_cnt++;
                    fsf_at = n;
                end
                if (32'(yf) > ymax) ymax = 32'(yf);
                hh = n % 800;
                vv = (n / 800) % 13;
                exp_x = (hh < 640 && vv < 6) ? hh : 0;
                exp_y = (hh < 640 && vv < 6) ? vv : 0;
                if (32'(xf) != exp_x || 32'(yf) != exp_y) coord_err++;
                if (!blf && {rf, gf, bf} != 24'h0) white_err++;
                if (blf && {rf, gf, bf} != 24'hFFFFFF) white_err++;
            end
        end

        chk("line_hs_low",   32'(hs_low),   32'd96);
        chk("line_hs_first", 32'(hs_first), 32'd657);
        chk("line_blank",    32'(bl_cnt),   32'd640);
        chk("line_hs3_first", 32'(hs3_first), 32'd659);
        chk("dut1_no_fs",    32'(fs1_cnt),  32'd0);
        chk("frm_vs_low",    32'(vs_low),   32'd1600);
        chk("frm_vs_first",  32'(vs_first), 32'd6401);
        chk("frm_fs_count",  32'(fsf_cnt),  32'd1);
        chk("frm_fs_period", 32'(fsf_at),   32'd10400);
        chk("frm_ymax",      32'(ymax),     32'd5);
        chk("frm_coord_err", 32'(coord_err), 32'd0);
        chk("frm_blank_cnt", 32'(blf_cnt),  32'd3840);
        chk("white_blanking", 32'(white_err), 32'd0);

        // ---------------- mid-scan reset on instance 1 at h=300, v=13 ----------------
        while (cyc < 10700) tick();
        chk("pre_rst_x", 32'(x1), 32'd300);
        chk("pre_rst_y", 32'(y1), 32'd13);
        chk("pre_rst_blank", 32'(bl1), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_hs",    32'(hs1), 32'd1);
        chk("mid_rst_vs",    32'(vs1), 32'd1);
        chk("mid_rst_blank", 32'(bl1), 32'd0);
        chk("mid_rst_rgb",   32'({r1, g1, b1}), 32'd0);
        chk("mid_rst_fs",    32'(fs1), 32'd0);
        chk("mid_rst_blank3", 32'(bl3), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("restart_fs", 32'(fs1), 32'd1);
        chk("restart_x",  32'(x1),  32'd0);
        chk("restart_y",  32'(y1),  32'd0);

        hs_low = 0; hs_first = -1; fs1_cnt = 0;
        for (int n = 1; n <= 800; n++) begin
            tick();
            if (!hs1) begin
                hs_low++;
                if (hs_first < 0) hs_first = n;
            end
            if (fs1) fs1_cnt++;
            if (n == 3) chk("restart_blank3", 32'(bl3), 32'd1);
        end
        chk("restart_hs_low",   32'(hs_low),   32'd96);
        chk("restart_hs_first", 32'(hs_first), 32'd657);
        chk("restart_no_fs",    32'(fs1_cnt),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_vga_scan_ctrl
`default_nettype wire
